// File: rtl/vmu_req_queue_pkg.sv
// ============================================================================
// Module : vmu_req_queue_pkg
// Brief  : Shared vector memory request/response types and microop constants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vmu_req_queue_pkg;

    localparam int VMU_ADDR_WIDTH     = 32;
    localparam int VMU_MICROOP_WIDTH  = 5;
    localparam int VMU_REQ_DATA_WIDTH = 256;
    localparam int VMU_SIZE_WIDTH     = 3;
    localparam int VMU_TICKET_WIDTH   = 8;

    localparam logic [VMU_MICROOP_WIDTH-1:0] VMU_MICROOP_LOAD  = 5'b00000;
    localparam logic [VMU_MICROOP_WIDTH-1:0] VMU_MICROOP_STORE = 5'b00100;

    typedef struct packed {
        logic [VMU_ADDR_WIDTH-1:0]     addr;
        logic [VMU_MICROOP_WIDTH-1:0]  microop;
        logic [VMU_SIZE_WIDTH-1:0]     size;
        logic [VMU_TICKET_WIDTH-1:0]   ticket;
        logic [VMU_REQ_DATA_WIDTH-1:0] data;
    } vector_mem_req;

    typedef struct packed {
        logic [VMU_TICKET_WIDTH-1:0]   ticket;
        logic [VMU_SIZE_WIDTH-1:0]     size;
        logic [VMU_REQ_DATA_WIDTH-1:0] data;
    } vector_mem_resp;

endpackage

`default_nettype wire

// File: rtl/vmu_req_queue_credit_cnt.sv
// ============================================================================
// Module : vmu_credit_cnt
// Brief  : Up/down saturating load-credit counter with sticky underflow error.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vmu_credit_cnt #(
    parameter int MAX_COUNT = 8,
    parameter int CW        = $clog2(MAX_COUNT) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_err
);

    localparam logic [CW-1:0] C_MAX = CW'(MAX_COUNT);

    logic [CW-1:0] r_count;
    logic          r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (i_inc && !i_dec) begin
            if (r_count != C_MAX)
                r_count <= r_count + 1'b1;
        end else if (!i_inc && i_dec) begin
            // A response with nothing outstanding is a cache protocol violation.
            if (r_count == '0)
                r_err <= 1'b1;
            else
                r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_err   = r_err;

endmodule

`default_nettype wire

// File: rtl/vmu_req_queue.sv
// ============================================================================
// Module : vmu_req_queue
// Brief  : VMU-to-dcache request FIFO with load credits and registered responses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vmu_req_queue
    import vmu_req_queue_pkg::*;
#(
    parameter int ADDR_WIDTH         = 32,
    parameter int MICROOP_WIDTH      = 5,
    parameter int REQ_DATA_WIDTH     = 256,
    parameter int DEPTH              = 4,
    parameter int MAX_LD_OUTSTANDING = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid_i,
    input  vector_mem_req  req_i,
    output logic           req_ready_o,
    output logic           cache_req_valid_o,
    output vector_mem_req  cache_req_o,
    input  logic           cache_req_ready_i,
    input  logic           cache_resp_valid_i,
    input  vector_mem_resp cache_resp_i,
    output logic           resp_valid_o,
    output vector_mem_resp resp_o,
    output logic           idle_o,
    output logic           err_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(MAX_LD_OUTSTANDING) + 1;

    // Struct widths are fixed by the shared package; a mismatched build raises err_o.
    localparam bit C_PARAMS_OK = (ADDR_WIDTH == VMU_ADDR_WIDTH) &&
                                 (MICROOP_WIDTH == VMU_MICROOP_WIDTH) &&
                                 (REQ_DATA_WIDTH == VMU_REQ_DATA_WIDTH) &&
                                 (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0);

    vector_mem_req  r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic           r_resp_valid;
    vector_mem_resp r_resp;

    logic           w_empty;
    logic           w_full;
    logic           w_enq;
    logic           w_deq;
    logic           w_ld_enq;
    logic [CW-1:0]  w_ld_credits;
    logic           w_credit_err;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]) && (r_wr_ptr[IW] != r_rd_ptr[IW]);

    // Ready is built from registered state only: the VMU grant logic uses it combinationally.
    assign req_ready_o       = !w_full && (w_ld_credits < CW'(MAX_LD_OUTSTANDING));
    assign cache_req_valid_o = !w_empty;
    assign cache_req_o       = r_mem[r_rd_ptr[IW-1:0]];

    assign w_enq    = req_valid_i && req_ready_o;
    assign w_deq    = cache_req_valid_o && cache_req_ready_i;
    assign w_ld_enq = w_enq && (req_i.microop == VMU_MICROOP_LOAD);

    always_ff @(posedge clk) begin
        if (w_enq)
            r_mem[r_wr_ptr[IW-1:0]] <= req_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp       <= '0;
        end else begin
            r_resp_valid <= cache_resp_valid_i;
            if (cache_resp_valid_i)
                r_resp <= cache_resp_i;
        end
    end

    vmu_credit_cnt #(
        .MAX_COUNT (MAX_LD_OUTSTANDING),
        .CW        (CW)
    ) u_credit_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_ld_enq),
        .i_dec   (cache_resp_valid_i),
        .o_count (w_ld_credits),
        .o_err   (w_credit_err)
    );

    assign resp_valid_o = r_resp_valid;
    assign resp_o       = r_resp;
    assign idle_o       = w_empty && (w_ld_credits == '0) && !r_resp_valid;
    assign err_o        = w_credit_err || !C_PARAMS_OK;

endmodule

`default_nettype wire

// File: tb/tb_vmu_req_queue.sv
// ============================================================================
// Module : tb_vmu_req_queue
// Brief  : Scoreboard-based self-checking bench for vmu_req_queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vmu_req_queue;
    import vmu_req_queue_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid_i;
    vector_mem_req  req_i;
    logic           req_ready_o;
    logic           cache_req_valid_o;
    vector_mem_req  cache_req_o;
    logic           cache_req_ready_i;
    logic           cache_resp_valid_i;
    vector_mem_resp cache_resp_i;
    logic           resp_valid_o;
    vector_mem_resp resp_o;
    logic           idle_o;
    logic           err_o;

    int total = 0;
    int bad   = 0;

    vector_mem_req  exp_req  [$];
    vector_mem_resp exp_resp [$];

    always #5 clk = ~clk;

    vmu_req_queue #(
        .ADDR_WIDTH         (32),
        .MICROOP_WIDTH      (5),
        .REQ_DATA_WIDTH     (256),
        .DEPTH              (4),
        .MAX_LD_OUTSTANDING (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_i        (req_valid_i),
        .req_i              (req_i),
        .req_ready_o        (req_ready_o),
        .cache_req_valid_o  (cache_req_valid_o),
        .cache_req_o        (cache_req_o),
        .cache_req_ready_i  (cache_req_ready_i),
        .cache_resp_valid_i (cache_resp_valid_i),
        .cache_resp_i       (cache_resp_i),
        .resp_valid_o       (resp_valid_o),
        .resp_o             (resp_o),
        .idle_o             (idle_o),
        .err_o              (err_o)
    );

    // Scoreboard: inputs are stable at the falling edge and describe the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_req.delete();
            exp_resp.delete();
        end else begin
            if (cache_req_valid_o && cache_req_ready_i) begin
                total++;
                if (exp_req.size() == 0) begin
                    bad++;
                    $display("FAIL sb_req: unexpected dequeue addr=%h ticket=%h", cache_req_o.addr, cache_req_o.ticket);
                end else begin
                    vector_mem_req e;
                    e = exp_req.pop_front();
                    if (cache_req_o !== e) begin
                        bad++;
                        $display("FAIL sb_req: got addr=%h op=%h ticket=%h, expected addr=%h op=%h ticket=%h",
                                 cache_req_o.addr, cache_req_o.microop, cache_req_o.ticket, e.addr, e.microop, e.ticket);
                    end
                end
            end
            if (req_valid_i && req_ready_o)
                exp_req.push_back(req_i);
            if (resp_valid_o) begin
                total++;
                if (exp_resp.size() == 0) begin
                    bad++;
                    $display("FAIL sb_resp: unexpected response ticket=%h", resp_o.ticket);
                end else begin
                    vector_mem_resp r;
                    r = exp_resp.pop_front();
                    if (resp_o !== r) begin
                        bad++;
                        $display("FAIL sb_resp: got ticket=%h data=%h, expected ticket=%h data=%h",
                                 resp_o.ticket, resp_o.data[31:0], r.ticket, r.data[31:0]);
                    end
                end
            end
            if (cache_resp_valid_i)
                exp_resp.push_back(cache_resp_i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vector_mem_req mk_req(logic [31:0] a, logic [4:0] op, logic [7:0] t);
        vector_mem_req q;
        q.addr    = a;
        q.microop = op;
        q.size    = 3'd5;
        q.ticket  = t;
        q.data    = {8{$urandom()}};
        return q;
    endfunction

    function automatic vector_mem_resp mk_resp(logic [7:0] t);
        vector_mem_resp p;
        p.ticket = t;
        p.size   = 3'd5;
        p.data   = {8{$urandom()}};
        return p;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total += 6;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b need 1", req_ready_o); end
        if (cache_req_valid_o !== 1'b0) begin bad++; $display("FAIL reset_cvalid: got %b need 0", cache_req_valid_o); end
        if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b need 0", resp_valid_o); end
        if (resp_o !== '0) begin bad++; $display("FAIL reset_resp: got ticket=%h need 0", resp_o.ticket); end
        if (idle_o !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b need 1", idle_o); end
        if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b need 0", err_o); end
    endtask

    task automatic test_stores();
        logic [31:0] a;
        cache_req_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 32'h100 + 32'(4 * i);
            req_valid_i = 1'b1;
            req_i = mk_req(a, VMU_MICROOP_STORE, 8'(i));
            if (i == 0) begin
                total++;
                if (cache_req_valid_o !== 1'b0) begin bad++; $display("FAIL store_nobypass: got %b need 0", cache_req_valid_o); end
            end
            tick();
            total += 3;
            if (cache_req_valid_o !== 1'b1) begin bad++; $display("FAIL store_valid[%0d]: got %b need 1", i, cache_req_valid_o); end
            if (cache_req_o.addr !== a) begin bad++; $display("FAIL store_head[%0d]: got %h need %h", i, cache_req_o.addr, a); end
            if (dut.w_ld_credits !== '0) begin bad++; $display("FAIL store_credits[%0d]: got %0d need 0", i, dut.w_ld_credits); end
        end
        req_valid_i = 1'b0;
        tick();
        total++;
        if (cache_req_valid_o !== 1'b0) begin bad++; $display("FAIL store_drained: got %b need 0", cache_req_valid_o); end
    endtask

    task automatic test_full();
        cache_req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid_i = 1'b1;
            req_i = mk_req(32'h100 + 32'(4 * i), VMU_MICROOP_STORE, 8'(16 + i));
            tick();
            total++;
            if (req_ready_o !== (i < 3)) begin bad++; $display("FAIL full_ready[%0d]: got %b need %b", i, req_ready_o, (i < 3)); end
        end
        req_valid_i = 1'b0;
        total += 2;
        if (cache_req_o.addr !== 32'h100) begin bad++; $display("FAIL full_head: got %h need 100", cache_req_o.addr); end
        cache_req_ready_i = 1'b1;
        if (req_ready_o !== 1'b0) begin bad++; $display("FAIL full_passthru: got %b need 0", req_ready_o); end
        tick();
        cache_req_ready_i = 1'b0;
        total += 2;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL full_reopen: got %b need 1", req_ready_o); end
        if (cache_req_o.addr !== 32'h104) begin bad++; $display("FAIL full_next_head: got %h need 104", cache_req_o.addr); end
        cache_req_ready_i = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (cache_req_valid_o !== 1'b0) begin bad++; $display("FAIL full_drained: got %b need 0", cache_req_valid_o); end
    endtask

    task automatic test_credits();
        cache_req_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (req_ready_o !== 1'b1) begin bad++; $display("FAIL ld_ready_pre[%0d]: got %b need 1", i, req_ready_o); end
            req_valid_i = 1'b1;
            req_i = mk_req(32'h2000 + 32'(i * 32), VMU_MICROOP_LOAD, 8'(i));
            tick();
        end
        req_valid_i = 1'b0;
        total += 2;
        if (req_ready_o !== 1'b0) begin bad++; $display("FAIL ld_ready_closed: got %b need 0", req_ready_o); end
        if (dut.w_ld_credits !== 4'd8) begin bad++; $display("FAIL ld_credits8: got %0d need 8", dut.w_ld_credits); end
        tick();
        cache_resp_valid_i = 1'b1;
        cache_resp_i = mk_resp(8'd3);
        tick();
        cache_resp_valid_i = 1'b0;
        total += 3;
        if (resp_valid_o !== 1'b1) begin bad++; $display("FAIL resp_valid: got %b need 1", resp_valid_o); end
        if (resp_o.ticket !== 8'd3) begin bad++; $display("FAIL resp_ticket: got %h need 03", resp_o.ticket); end
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL ld_reopen: got %b need 1", req_ready_o); end
        tick();
        total += 2;
        if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL resp_pulse: got %b need 0", resp_valid_o); end
        if (resp_o.ticket !== 8'd3) begin bad++; $display("FAIL resp_hold: got %h need 03", resp_o.ticket); end
    endtask

    task automatic test_simul();
        for (int i = 0; i < 2; i++) begin
            cache_resp_valid_i = 1'b1;
            cache_resp_i = mk_resp(8'(10 + i));
            tick();
        end
        req_valid_i = 1'b1;
        req_i = mk_req(32'h3000, VMU_MICROOP_LOAD, 8'd20);
        cache_resp_i = mk_resp(8'd12);
        tick();
        cache_resp_valid_i = 1'b0;
        total++;
        if (dut.w_ld_credits !== 4'd5) begin bad++; $display("FAIL simul_credits: got %0d need 5", dut.w_ld_credits); end
        for (int i = 0; i < 3; i++) begin
            req_i = mk_req(32'h3040 + 32'(i * 32), VMU_MICROOP_LOAD, 8'(21 + i));
            tick();
            total++;
            if (req_ready_o !== (i < 2)) begin bad++; $display("FAIL simul_ready[%0d]: got %b need %b", i, req_ready_o, (i < 2)); end
        end
        req_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cache_resp_valid_i = 1'b1;
            cache_resp_i = mk_resp(8'(40 + i));
            tick();
        end
        cache_resp_valid_i = 1'b0;
        tick();
        total++;
        if (idle_o !== 1'b1) begin bad++; $display("FAIL simul_idle: got %b need 1", idle_o); end
    endtask

    task automatic test_err();
        cache_resp_valid_i = 1'b1;
        cache_resp_i = mk_resp(8'h55);
        tick();
        cache_resp_valid_i = 1'b0;
        total += 2;
        if (err_o !== 1'b1) begin bad++; $display("FAIL err_set: got %b need 1", err_o); end
        if (dut.w_ld_credits !== '0) begin bad++; $display("FAIL err_credits: got %0d need 0", dut.w_ld_credits); end
        tick();
        tick();
        total += 2;
        if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b need 1", err_o); end
        if (dut.w_ld_credits !== '0) begin bad++; $display("FAIL err_credits_hold: got %0d need 0", dut.w_ld_credits); end
    endtask

    task automatic test_rst_mid();
        cache_req_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_i = mk_req(32'h4000, VMU_MICROOP_LOAD, 8'd60);
        tick();
        req_i = mk_req(32'h4020, VMU_MICROOP_LOAD, 8'd61);
        tick();
        req_i = mk_req(32'h4040, VMU_MICROOP_STORE, 8'd62);
        tick();
        req_valid_i = 1'b0;
        total += 2;
        if (cache_req_valid_o !== 1'b1 || idle_o !== 1'b0) begin
            bad++; $display("FAIL rst_pre: got valid=%b idle=%b need valid=1 idle=0", cache_req_valid_o, idle_o);
        end
        if (dut.w_ld_credits !== 4'd2) begin bad++; $display("FAIL rst_pre_credits: got %0d need 2", dut.w_ld_credits); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total += 4;
        if (cache_req_valid_o !== 1'b0) begin bad++; $display("FAIL rst_cvalid: got %b need 0", cache_req_valid_o); end
        if (idle_o !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b need 1", idle_o); end
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b need 1", req_ready_o); end
        if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b need 0", err_o); end
    endtask

    task automatic test_back_to_back();
        cache_req_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid_i = 1'b1;
            req_i = mk_req($urandom(), VMU_MICROOP_STORE, 8'($urandom_range(0, 255)));
            tick();
            total++;
            if (req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b need 1", i, req_ready_o); end
        end
        req_valid_i = 1'b0;
        tick();
        tick();
        total += 2;
        if (exp_req.size() != 0) begin bad++; $display("FAIL b2b_sb_req_left: got %0d need 0", exp_req.size()); end
        if (exp_resp.size() != 0) begin bad++; $display("FAIL b2b_sb_resp_left: got %0d need 0", exp_resp.size()); end
    endtask

    initial begin
        rst                = 1'b1;
        req_valid_i        = 1'b0;
        req_i              = '0;
        cache_req_ready_i  = 1'b0;
        cache_resp_valid_i = 1'b0;
        cache_resp_i       = '0;
        test_reset();
        test_stores();
        test_full();
        test_credits();
        test_simul();
        test_err();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
